param_systolic_array: RTL and testbench
=======================================

PARAM_SYSTOLIC_ARRAY -- requirements
Module: param_systolic_array

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows (1..16).
REQ-002 Parameter COLS, default 4, number of PE columns (1..16).
REQ-003 Parameter DATA_W, default 16, signed operand width.
REQ-004 Parameter ACC_W, default 40, signed accumulator width (>= 2*DATA_W).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request new matrix product; sampled only in IDLE.
REQ-008 k_len  input  8  inner dimension K, captured when start accepted.
REQ-009 in_valid  input  1  operand beat valid.
REQ-010 in_ready  output  1  array accepts operand beat.
REQ-011 a_col  input  ROWS*DATA_W  column k of A; element i at bits [i*DATA_W +: DATA_W].
REQ-012 b_row  input  COLS*DATA_W  row k of B; element j at bits [j*DATA_W +: DATA_W].
REQ-013 out_valid  output  1  result row valid.
REQ-014 out_ready  input  1  consumer accepts result row.
REQ-015 out_row  output  COLS*ACC_W  row out_idx of C; element j at [j*ACC_W +: ACC_W].
REQ-016 out_idx  output  $clog2(ROWS) (min 1)  index of row on out_row.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse after last row handshake.

Function
REQ-019 Block SHALL compute C = A*B (ROWS x K times K x COLS), output-stationary, one accumulator per PE.
REQ-020 FSM SHALL have states IDLE, LOAD, DRAIN, OUT.
REQ-021 IDLE: start=1 and k_len!=0 -> LOAD; start=1 and k_len=0 -> OUT with all-zero C; accumulators cleared on the accepting edge.
REQ-022 start SHALL be ignored in LOAD, DRAIN, OUT.
REQ-023 in_ready SHALL be 1 only in LOAD; a beat transfers when in_valid and in_ready both high.
REQ-024 LOAD SHALL count transferred beats; on the edge accepting beat K it SHALL go to DRAIN.
REQ-025 Cycles in LOAD without a transfer SHALL inject zero operands; result SHALL equal gap-free streaming.
REQ-026 Row i of A SHALL pass i skew registers, column j of B j skew registers, before entering the array.
REQ-027 Each PE SHALL register a eastward and b southward and add sign-extended a*b to its accumulator every cycle.
REQ-028 Accumulator SHALL wrap modulo 2^ACC_W; no saturation.
REQ-029 DRAIN SHALL inject zeros for exactly ROWS+COLS-1 cycles, then go to OUT.
REQ-030 OUT: out_valid=1, out_idx starts at 0, increments on each out_valid&out_ready.
REQ-031 out_row and out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 Handshake on row ROWS-1 SHALL go to IDLE and pulse done on the following cycle.
REQ-033 Accumulators SHALL hold their values in OUT and IDLE until next accepted start.

Reset
REQ-034 Reset asserted SHALL force IDLE, clear all accumulators, skew and PE pipeline registers, and beat/drain/row counters.
REQ-035 During and after reset: in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0.
REQ-036 Reset in any state mid-operation SHALL abandon it; no done pulse.

Structure
REQ-037 Package systolic_pkg SHALL hold FSM state encoding and default ROWS/COLS/DATA_W/ACC_W constants.
REQ-038 Single sub-module systolic_pe (registered a/b pass-through plus MAC, synchronous clear) SHALL be instantiated ROWS x COLS via generate.
REQ-039 Skew registers, counters, FSM, output mux SHALL live in param_systolic_array.

Verification (defaults 4x4, DATA_W 16, ACC_W 40)
REQ-040 Reset mid-LOAD (after 2 beats) -> IDLE next cycle, in_ready=0, then K=1 run yields correct C with no residue.
REQ-041 K=1, a_col={4,3,2,1} (elements 0..3 = 1,2,3,4), b_row all 1 -> row i = {i+1 x4}; out_valid after 1+7 cycles.
REQ-042 K=4, A=identity, B[k][j]=10k+j, in_valid toggling every cycle -> C=B exactly.
REQ-043 K=1, all A=-3, all B=5 -> every element 0xFFFFFFFFF1 (-15).
REQ-044 out_ready low 3 cycles in OUT -> row 0 held stable; done pulses once after row 3.
REQ-045 start with k_len=0 -> OUT immediately, four all-zero rows; start during OUT ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the parameterised systolic array.
package systolic_pkg;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: forwards a east and b south through
// one register each and accumulates the signed product into a wrapping
// accumulator.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);

    // Operand pass-through and MAC; clr wipes the PE at the start of a product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/param_systolic_array.sv
// ROWS x COLS output-stationary systolic array computing C = A*B.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge (in_valid /
// in_ready for operand beats, out_valid / out_ready for result rows).
module param_systolic_array
    import systolic_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_W-1:0]     a_col,
    input  logic [COLS*DATA_W-1:0]     b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_W-1:0]      out_row,
    output logic [idx_width(ROWS)-1:0] out_idx,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 state_dbg
);

    localparam int          IDX_W      = idx_width(ROWS);
    localparam logic [7:0]  DRAIN_LAST = 8'(ROWS + COLS - 2);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

    state_t           state;
    logic [7:0]       k_reg;
    logic [7:0]       beat_cnt;
    logic [7:0]       drain_cnt;
    logic [IDX_W-1:0] row_cnt;

    logic accept;
    logic xfer;
    logic en;

    assign accept    = (state == ST_IDLE) && start;
    assign xfer      = in_valid && in_ready;
    assign en        = (state == ST_LOAD) || (state == ST_DRAIN);
    assign out_idx   = row_cnt;
    assign state_dbg = state;

    // Operands entering the skew network; idle LOAD cycles and DRAIN push zeros.
    logic [DATA_W-1:0] a_inj  [ROWS];
    logic [DATA_W-1:0] b_inj  [COLS];
    logic [DATA_W-1:0] a_edge [ROWS];
    logic [DATA_W-1:0] b_edge [COLS];

    logic [DATA_W-1:0] a_h    [ROWS][COLS];
    logic [DATA_W-1:0] b_v    [ROWS][COLS];
    logic [ACC_W-1:0]  acc_q  [ROWS][COLS];

    genvar gi, gj;

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
            assign a_inj[gi] = xfer ? a_col[gi*DATA_W +: DATA_W] : '0;
            if (gi == 0) begin : g_direct
                assign a_edge[gi] = a_inj[gi];
            end else begin : g_sr
                logic [DATA_W-1:0] sr [gi];
                // Row gi is delayed gi cycles so it meets column data diagonally.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int s = 0; s < gi; s++) sr[s] <= '0;
                    end else if (accept) begin
                        for (int s = 0; s < gi; s++) sr[s] <= '0;
                    end else if (en) begin
                        sr[0] <= a_inj[gi];
                        for (int s = 1; s < gi; s++) sr[s] <= sr[s-1];
                    end
                end
                assign a_edge[gi] = sr[gi-1];
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_b_skew
            assign b_inj[gj] = xfer ? b_row[gj*DATA_W +: DATA_W] : '0;
            if (gj == 0) begin : g_direct
                assign b_edge[gj] = b_inj[gj];
            end else begin : g_sr
                logic [DATA_W-1:0] sr [gj];
                // Column gj is delayed gj cycles to line up with the row skew.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int s = 0; s < gj; s++) sr[s] <= '0;
                    end else if (accept) begin
                        for (int s = 0; s < gj; s++) sr[s] <= '0;
                    end else if (en) begin
                        sr[0] <= b_inj[gj];
                        for (int s = 1; s < gj; s++) sr[s] <= sr[s-1];
                    end
                end
                assign b_edge[gj] = sr[gj-1];
            end
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic [DATA_W-1:0] a_w;
                logic [DATA_W-1:0] b_w;
                if (gj == 0) begin : g_a_west
                    assign a_w = a_edge[gi];
                end else begin : g_a_pe
                    assign a_w = a_h[gi][gj-1];
                end
                if (gi == 0) begin : g_b_north
                    assign b_w = b_edge[gj];
                end else begin : g_b_pe
                    assign b_w = b_v[gi-1][gj];
                end
                systolic_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W)
                ) u_pe (
                    .clk   (clk),
                    .reset (reset),
                    .clr   (accept),
                    .en    (en),
                    .a_in  (a_w),
                    .b_in  (b_w),
                    .a_out (a_h[gi][gj]),
                    .b_out (b_v[gi][gj]),
                    .acc   (acc_q[gi][gj])
                );
            end
        end
    endgenerate

    // Result row selected by the row counter; accumulators hold in OUT/IDLE.
    always_comb begin
        out_row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (int'(row_cnt) == i) begin
                for (int j = 0; j < COLS; j++) begin
                    out_row[j*ACC_W +: ACC_W] = acc_q[i][j];
                end
            end
        end
    end

    // Control FSM with counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        row_cnt   <= '0;
                        busy      <= 1'b1;
                        if (k_len != 8'd0) begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= ST_OUT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        if (beat_cnt == k_reg - 8'd1) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (row_cnt == ROW_LAST) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            row_cnt   <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_systolic_array.sv
// Directed, table-driven bench for the default 4x4 systolic array.
module tb_param_systolic_array;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int AW = 40;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      k_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [R*DW-1:0] a_col = '0;
    logic [C*DW-1:0] b_row = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [C*AW-1:0] out_row;
    logic [1:0]      out_idx;
    logic            busy;
    logic            done;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    param_systolic_array dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Vector table: a[i][k], b[k][j], expected c[i][j]
    typedef struct {
        int  k;
        bit  gaps;
        bit  chk_lat;
        logic [3:0][3:0][DW-1:0] a;
        logic [3:0][3:0][DW-1:0] b;
        logic [3:0][3:0][AW-1:0] c;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input int r, input logic [3:0][AW-1:0] exp_row);
        check($sformatf("%s out_idx", tag), 64'(out_idx), 64'(r));
        check($sformatf("%s out_valid", tag), 64'(out_valid), 64'd1);
        for (int j = 0; j < C; j++)
            check($sformatf("%s c[%0d][%0d]", tag, r, j), 64'(out_row[j*AW +: AW]), 64'(exp_row[j]));
    endtask

    task automatic drive_beat(input int v, input int kk);
        for (int i = 0; i < R; i++) a_col[i*DW +: DW] = vecs[v].a[i][kk];
        for (int j = 0; j < C; j++) b_row[j*DW +: DW] = vecs[v].b[kk][j];
        in_valid = 1'b1;
    endtask

    // Full product: start, stream K beats, wait, collect rows (row 0 stalled)
    task automatic run_vec(input int v, input int stall);
        int lat;
        int budget;
        int done_cnt;
        check($sformatf("v%0d idle busy", v), 64'(busy), 64'd0);
        start = 1'b1;
        k_len = 8'(vecs[v].k);
        tick();
        start = 1'b0;
        lat = 0;
        check($sformatf("v%0d load busy", v), 64'(busy), 64'd1);
        check($sformatf("v%0d load in_ready", v), 64'(in_ready), 64'd1);
        for (int kk = 0; kk < vecs[v].k; kk++) begin
            if (vecs[v].gaps && kk > 0) begin
                in_valid = 1'b0;
                a_col = {$urandom, $urandom};
                b_row = {$urandom, $urandom};
                tick();
                lat++;
            end
            drive_beat(v, kk);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
        budget = 100;
        while (!out_valid && budget > 0) begin
            tick();
            lat++;
            budget--;
        end
        check($sformatf("v%0d out_valid timeout", v), 64'(out_valid), 64'd1);
        if (vecs[v].chk_lat) check($sformatf("v%0d latency", v), 64'(lat), 64'd8);
        for (int r = 0; r < R; r++) begin
            if (r == 0) begin
                for (int s = 0; s < stall; s++) begin
                    out_ready = 1'b0;
                    check_row($sformatf("v%0d stall%0d", v, s), 0, vecs[v].c[0]);
                    tick();
                end
            end
            out_ready = 1'b1;
            check_row($sformatf("v%0d row", v), r, vecs[v].c[r]);
            tick();
        end
        out_ready = 1'b0;
        check($sformatf("v%0d done", v), 64'(done), 64'd1);
        check($sformatf("v%0d out_valid after", v), 64'(out_valid), 64'd0);
        done_cnt = 1;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (done) done_cnt++;
        end
        check($sformatf("v%0d done pulses", v), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d busy after", v), 64'(busy), 64'd0);
    endtask

    initial begin
        // Table setup
        for (int v = 0; v < 4; v++) begin
            vecs[v].k = 0;
            vecs[v].gaps = 1'b0;
            vecs[v].chk_lat = 1'b0;
            vecs[v].a = '0;
            vecs[v].b = '0;
            vecs[v].c = '0;
        end
        // v0: K=1, column {1,2,3,4}, B all ones -> row i = i+1
        vecs[0].k = 1;
        vecs[0].chk_lat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vecs[0].a[i][0] = DW'(i + 1);
            vecs[0].b[0][i] = DW'(1);
            for (int j = 0; j < 4; j++) vecs[0].c[i][j] = AW'(i + 1);
        end
        // v1: K=4, A identity, B[k][j]=10k+j, gapped stream -> C = B
        vecs[1].k = 4;
        vecs[1].gaps = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vecs[1].a[i][i] = DW'(1);
            for (int j = 0; j < 4; j++) begin
                vecs[1].b[i][j] = DW'(10 * i + j);
                vecs[1].c[i][j] = AW'(10 * i + j);
            end
        end
        // v2: K=1, A=-3, B=5 -> -15 everywhere
        vecs[2].k = 1;
        for (int i = 0; i < 4; i++) begin
            vecs[2].a[i][0] = DW'(-3);
            vecs[2].b[0][i] = DW'(5);
            for (int j = 0; j < 4; j++) vecs[2].c[i][j] = 40'hFFFFFFFFF1;
        end
        // v3: K=2 mixed signs
        vecs[3].k = 2;
        vecs[3].a[0][0] = DW'(1);  vecs[3].a[0][1] = DW'(2);
        vecs[3].a[1][0] = DW'(3);  vecs[3].a[1][1] = DW'(4);
        vecs[3].a[2][0] = DW'(-1); vecs[3].a[2][1] = DW'(0);
        vecs[3].a[3][0] = DW'(2);  vecs[3].a[3][1] = DW'(-2);
        vecs[3].b[0][0] = DW'(5);  vecs[3].b[0][1] = DW'(6);
        vecs[3].b[0][2] = DW'(7);  vecs[3].b[0][3] = DW'(8);
        vecs[3].b[1][0] = DW'(1);  vecs[3].b[1][1] = DW'(-1);
        vecs[3].b[1][2] = DW'(2);  vecs[3].b[1][3] = DW'(0);
        vecs[3].c[0][0] = AW'(7);  vecs[3].c[0][1] = AW'(4);
        vecs[3].c[0][2] = AW'(11); vecs[3].c[0][3] = AW'(8);
        vecs[3].c[1][0] = AW'(19); vecs[3].c[1][1] = AW'(14);
        vecs[3].c[1][2] = AW'(29); vecs[3].c[1][3] = AW'(24);
        vecs[3].c[2][0] = AW'(-5); vecs[3].c[2][1] = AW'(-6);
        vecs[3].c[2][2] = AW'(-7); vecs[3].c[2][3] = AW'(-8);
        vecs[3].c[3][0] = AW'(8);  vecs[3].c[3][1] = AW'(14);
        vecs[3].c[3][2] = AW'(10); vecs[3].c[3][3] = AW'(16);

        // Reset values
        #12;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_row", 64'(out_row[63:0]) | 64'(out_row[C*AW-1:C*AW-64]), 64'd0);
        check("rst out_idx", 64'(out_idx), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post rst state", 64'(state_dbg), 64'd0);

        // Table-driven runs
        for (int v = 0; v < 4; v++) run_vec(v, 0);

        // Output stall: row 0 held for three cycles, single done pulse
        run_vec(3, 3);

        // Reset mid-LOAD after two beats, then a clean K=1 run
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start = 1'b0;
        drive_beat(1, 0);
        tick();
        drive_beat(1, 1);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midload rst in_ready", 64'(in_ready), 64'd0);
        check("midload rst busy", 64'(busy), 64'd0);
        check("midload rst state", 64'(state_dbg), 64'd0);
        tick();
        reset = 1'b0;
        check("midload rst done", 64'(done), 64'd0);
        tick();
        run_vec(0, 0);

        // k_len=0: straight to OUT with zero rows, start ignored in OUT
        start = 1'b1;
        k_len = 8'd0;
        tick();
        start = 1'b0;
        check("k0 busy", 64'(busy), 64'd1);
        check("k0 in_ready", 64'(in_ready), 64'd0);
        check("k0 state", 64'(state_dbg), 64'd3);
        start = 1'b1;
        k_len = 8'd2;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        check("k0 start ignored state", 64'(state_dbg), 64'd3);
        for (int r = 0; r < R; r++) begin
            out_ready = 1'b1;
            check_row("k0", r, '0);
            tick();
        end
        out_ready = 1'b0;
        check("k0 done", 64'(done), 64'd1);
        tick();
        check("k0 done cleared", 64'(done), 64'd0);
        check("k0 idle", 64'(state_dbg), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
